// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-FF sync, 3-sample majority vote, parity/stop checking, break detect, RX queue.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [DIV_W-1:0]                delay,
    input  logic [1:0]                      parity_mode,
    input  logic                            stop2,
    input  logic                            rx,
    input  logic                            rd,
    input  logic                            ovr_clr,
    output logic [DATA_BITS-1:0]            out,
    output logic                            perr,
    output logic                            ferr,
    output logic                            valid,
    output logic [$clog2(FIFO_DEPTH):0]     level,
    output logic                            overrun,
    output logic                            brk
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic                 rx_m, rx_s, rx_h1, rx_h2;
    logic [1:0]           fill;
    logic                 armed;
    logic [2:0]           state;
    logic [DIV_W-1:0]     cnt, dly_q;
    logic [1:0]           pm_q;
    logic                 st2_q, stop_left;
    logic [BW-1:0]        bitcnt;
    logic [DATA_BITS-1:0] sr;
    logic                 perr_q, ferr_q, zero_q;
    logic                 vote, tick, start, par_en;
    logic                 push, push_ok, pop, full, w_ferr, w_brk;
    logic [LW-1:0]        level_q;
    logic                 ovr_q, brk_q;
    logic [DATA_BITS+1:0] head, wr_word;

    assign vote   = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
    assign tick   = (cnt == '0);
    assign par_en = pm_q[0] ^ pm_q[1];
    // armed only after a genuine high has passed through the synchronizer, so a
    // line held low across reset release is not taken for a start edge
    assign start  = (state == S_IDLE) && armed && rx_h1 && !rx_s;

    always_comb begin
        push   = 1'b0;
        w_ferr = ferr_q | ~vote;
        w_brk  = zero_q & ~vote;
        if (state == S_STOP && tick && !stop_left) push = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            rx_h1     <= 1'b1;
            rx_h2     <= 1'b1;
            fill      <= 2'd0;
            armed     <= 1'b0;
            state     <= S_IDLE;
            cnt       <= '0;
            dly_q     <= '0;
            pm_q      <= 2'b00;
            st2_q     <= 1'b0;
            stop_left <= 1'b0;
            bitcnt    <= '0;
            sr        <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            rx_m  <= rx;
            rx_s  <= rx_m;
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
            if (fill != 2'd2) fill <= fill + 2'd1;
            if (fill == 2'd2 && rx_s) armed <= 1'b1;
            if (state != S_IDLE && !tick) cnt <= cnt - DIV_W'(1);
            case (state)
                S_IDLE: if (start) begin
                    state <= S_START;
                    cnt   <= (delay >> 1) - DIV_W'(1);
                end
                S_START: if (tick) begin
                    if (vote) state <= S_IDLE;
                    else begin
                        state  <= S_DATA;
                        dly_q  <= delay;
                        pm_q   <= parity_mode;
                        st2_q  <= stop2;
                        cnt    <= delay - DIV_W'(1);
                        bitcnt <= BW'(DATA_BITS);
                        perr_q <= 1'b0;
                        ferr_q <= 1'b0;
                        zero_q <= 1'b1;
                    end
                end
                S_DATA: if (tick) begin
                    sr     <= {vote, sr[DATA_BITS-1:1]};
                    zero_q <= zero_q & ~vote;
                    cnt    <= dly_q - DIV_W'(1);
                    bitcnt <= bitcnt - BW'(1);
                    if (bitcnt == BW'(1)) begin
                        state     <= par_en ? S_PARITY : S_STOP;
                        stop_left <= st2_q;
                    end
                end
                S_PARITY: if (tick) begin
                    // even (01): XOR of data and parity must be 0; odd (10): must be 1
                    perr_q <= (^sr) ^ vote ^ pm_q[1];
                    zero_q <= zero_q & ~vote;
                    cnt    <= dly_q - DIV_W'(1);
                    state  <= S_STOP;
                end
                S_STOP: if (tick) begin
                    if (stop_left) begin
                        ferr_q    <= w_ferr;
                        zero_q    <= w_brk;
                        stop_left <= 1'b0;
                        cnt       <= dly_q - DIV_W'(1);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wr_word = {perr_q, w_ferr, sr};
    assign valid   = (level_q != '0);
    assign pop     = rd && valid;
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push && (!full || pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wp, rp;

    assign full = (level_q == LW'(FIFO_DEPTH));
    assign head = mem[rp];

    always_ff @(posedge clock) begin
        if (push_ok) mem[wp] <= wr_word;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop)     rp <= rp + AW'(1);
        end
    end
`else
    logic [DATA_BITS+1:0] hold;

    assign full = valid;
    assign head = hold;

    always_ff @(posedge clock) begin
        if (!reset_n)     hold <= '0;
        else if (push_ok) hold <= wr_word;
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            level_q <= '0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            case ({push_ok, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            if (push && !push_ok) ovr_q <= 1'b1;
            else if (ovr_clr)     ovr_q <= 1'b0;
            brk_q <= push && w_brk;
        end
    end

    assign out     = valid ? head[DATA_BITS-1:0] : '0;
    assign perr    = valid & head[DATA_BITS+1];
    assign ferr    = valid & head[DATA_BITS];
    assign level   = level_q;
    assign overrun = ovr_q;
    assign brk     = brk_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames are queued as expected words, a monitor pops and compares.
module tb_uart_rx_fifo;
    localparam int DB  = 8;
    localparam int DW  = 16;
    localparam int FD  = 4;
    localparam int DLY = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] delay = DW'(DLY);
    logic [1:0]    parity_mode = 2'b00;
    logic          stop2 = 1'b0;
    logic          rx = 1'b1;
    logic          rd = 1'b0;
    logic          ovr_clr = 1'b0;
    logic [DB-1:0] out;
    logic          perr, ferr, valid, overrun, brk;
    logic [$clog2(FD):0] level;

    uart_rx_fifo #(.DATA_BITS(DB), .DIV_W(DW), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset_n(reset_n), .delay(delay), .parity_mode(parity_mode),
        .stop2(stop2), .rx(rx), .rd(rd), .ovr_clr(ovr_clr), .out(out), .perr(perr),
        .ferr(ferr), .valid(valid), .level(level), .overrun(overrun), .brk(brk)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    exp_t q[$];
    int   vec = 0;
    int   bad = 0;
    bit   mon_en = 1'b1;
    int   brk_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_word(input logic [7:0] d, input logic p, input logic f);
        exp_t e;
        e.d = d; e.p = p; e.f = f;
        q.push_back(e);
    endtask

    // monitor: compare and pop the head whenever the DUT presents a word
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_word", {22'd0, out, perr, ferr}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rx_word", {22'd0, out, perr, ferr}, {22'd0, e.d, e.p, e.f});
                end
                rd = 1'b1;
                @(negedge clock);
                rd = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (brk) brk_hi++;
        end
    end

    // start, data LSB first, optional parity, one or two stop bits; optional 1-cycle inverted spike
    task automatic send(input logic [7:0] d, input bit use_par, input logic pb,
                        input logic s1, input bit two, input logic s2, input int spike);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (use_par) bits.push_back(pb);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        for (int b = 0; b < bits.size(); b++) begin
            for (int c = 0; c < DLY; c++) begin
                @(negedge clock);
                rx = (b == spike && c == DLY / 2) ? ~bits[b] : bits[b];
            end
        end
        @(negedge clock);
        rx = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic send8(input logic [7:0] d);
        send(d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || valid) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        chk("drain_timeout", n < 2000, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out", out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_brk", brk, 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_outputs();
        reset_n = 1'b1;
        repeat (6) @(negedge clock);

        // basic byte, held for a level check before the monitor reads it
        mon_en = 1'b0;
        send8(8'hA5);
        chk("a5_valid", valid, 1);
        chk("a5_level", level, 1);
        expect_word(8'hA5, 1'b0, 1'b0);
        mon_en = 1'b1;
        drain();

        // parity: 0x03 has even weight
        parity_mode = 2'b01;
        expect_word(8'h03, 1'b1, 1'b0); send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        expect_word(8'h03, 1'b0, 1'b0); send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        parity_mode = 2'b10;
        expect_word(8'h03, 1'b0, 1'b0); send(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        expect_word(8'h03, 1'b1, 1'b0); send(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        drain();
        parity_mode = 2'b00;

        // 4-cycle low glitch is a false start
        @(negedge clock); rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        chk("glitch_valid", valid, 0);

        // 1-cycle spike at the sample point of data bit 2 (a 0 bit) is outvoted
        expect_word(8'hC3, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        drain();

        // two stop bits, second low -> framing error
        stop2 = 1'b1;
        expect_word(8'h3C, 1'b0, 1'b1);
        send(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        drain();

        // break frame
        brk_hi = 0;
        expect_word(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        drain();
        chk("brk_cycles", brk_hi, 1);
        stop2 = 1'b0;
        repeat (10) @(negedge clock);

        // overrun: nothing read while frames arrive
        mon_en = 1'b0;
`ifdef UART_RX_FIFO_EN
        send8(8'h11); send8(8'h22); send8(8'h33); send8(8'h44); send8(8'h55);
        chk("ovr_level", level, FD);
        chk("ovr_flag", overrun, 1);
        expect_word(8'h11, 1'b0, 1'b0);
        expect_word(8'h22, 1'b0, 1'b0);
        expect_word(8'h33, 1'b0, 1'b0);
        expect_word(8'h44, 1'b0, 1'b0);
`else
        send8(8'h11); send8(8'h22);
        chk("ovr_level", level, 1);
        chk("ovr_flag", overrun, 1);
        expect_word(8'h11, 1'b0, 1'b0);
`endif
        mon_en = 1'b1;
        drain();
        chk("ovr_sticky", overrun, 1);
        @(negedge clock); ovr_clr = 1'b1;
        @(negedge clock); ovr_clr = 1'b0;
        chk("ovr_cleared", overrun, 0);

        // reset mid-byte, line held low through reset release
        @(negedge clock); rx = 1'b0;
        repeat (DLY + 8) @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_reset_outputs();
        reset_n = 1'b1;
        repeat (30) @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        chk("rst_low_no_frame", valid, 0);
        expect_word(8'h5A, 1'b0, 1'b0);
        send8(8'h5A);
        drain();
        repeat (20) @(negedge clock);
        chk("final_empty", valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
